// File: rtl/sort4_stream_ctrl.sv
// Stream sequencer around an external 4-input sorter: gathers up to 4 samples,
// presents them to the sorter, then replays the sorted group serially.
module sort4_stream_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode_asc,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic [WIDTH-1:0] srt_a,
  output logic [WIDTH-1:0] srt_b,
  output logic [WIDTH-1:0] srt_c,
  output logic [WIDTH-1:0] srt_d,
  input  logic [WIDTH-1:0] srt_max,
  input  logic [WIDTH-1:0] srt_midh,
  input  logic [WIDTH-1:0] srt_midl,
  input  logic [WIDTH-1:0] srt_min,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] grp_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                    state_r, state_s;
  logic [2:0]                cnt_r, cnt_s;
  logic [2:0]                n_r, n_s;
  logic [1:0]                idx_r, idx_s;
  logic                      asc_r, asc_s;
  logic [3:0][WIDTH-1:0]     slot_r, slot_s;
  logic [3:0][WIDTH-1:0]     res_r, res_s;
  logic [CNT_W-1:0]          grp_r, grp_s;
  logic                      in_ready_r, out_valid_r, out_last_r, busy_r;
  logic [WIDTH-1:0]          out_data_r;
  logic                      in_acc_s, out_acc_s;
  logic                      out_last_s;

  assign in_acc_s  = in_valid & in_ready_r;
  assign out_acc_s = out_valid_r & out_ready;

  // Next-state, slot/result and counter update logic
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    n_s     = n_r;
    idx_s   = idx_r;
    asc_s   = asc_r;
    slot_s  = slot_r;
    res_s   = res_r;
    grp_s   = grp_r;
    case (state_r)
      FILL: begin
        if (in_acc_s) begin
          slot_s[cnt_r[1:0]] = in_data;
          cnt_s              = cnt_r + 3'd1;
          if ((cnt_r == 3'd3) || in_last) begin
            state_s = SORT;
            n_s     = cnt_r + 3'd1;
            asc_s   = mode_asc;
            // Pads sort to the tail in either direction, so they are never emitted
            for (int i = 0; i < 4; i++) begin
              if (3'(i) > cnt_r) begin
                slot_s[i] = mode_asc ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
              end else begin
                slot_s[i] = slot_s[i];
              end
            end
          end else begin
            state_s = FILL;
          end
        end else begin
          state_s = FILL;
        end
      end
      SORT: begin
        res_s   = asc_r ? {srt_max, srt_midh, srt_midl, srt_min}
                        : {srt_min, srt_midl, srt_midh, srt_max};
        idx_s   = 2'd0;
        state_s = DRAIN;
      end
      DRAIN: begin
        if (out_acc_s) begin
          if ({1'b0, idx_r} == (n_r - 3'd1)) begin
            state_s = FILL;
            cnt_s   = 3'd0;
            idx_s   = 2'd0;
            grp_s   = grp_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            idx_s   = idx_r + 2'd1;
          end
        end else begin
          idx_s = idx_r;
        end
      end
      default: begin
        state_s = FILL;
        cnt_s   = 3'd0;
        idx_s   = 2'd0;
      end
    endcase
  end

  // Output values derived from the upcoming state so the ports come straight from flops
  always_comb begin
    if ((state_s == DRAIN) && ({1'b0, idx_s} == (n_s - 3'd1))) begin
      out_last_s = 1'b1;
    end else begin
      out_last_s = 1'b0;
    end
  end

  // State, datapath and registered output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= FILL;
      cnt_r       <= 3'd0;
      n_r         <= 3'd0;
      idx_r       <= 2'd0;
      asc_r       <= 1'b0;
      slot_r      <= '0;
      res_r       <= '0;
      grp_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= '0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      n_r         <= n_s;
      idx_r       <= idx_s;
      asc_r       <= asc_s;
      slot_r      <= slot_s;
      res_r       <= res_s;
      grp_r       <= grp_s;
      in_ready_r  <= (state_s == FILL);
      out_valid_r <= (state_s == DRAIN);
      out_last_r  <= out_last_s;
      out_data_r  <= (state_s == DRAIN) ? res_s[idx_s] : {WIDTH{1'b0}};
      busy_r      <= (state_s != FILL) || (cnt_s != 3'd0);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign out_data  = out_data_r;
  assign grp_cnt   = grp_r;
  assign busy      = busy_r;
  assign srt_a     = slot_r[0];
  assign srt_b     = slot_r[1];
  assign srt_c     = slot_r[2];
  assign srt_d     = slot_r[3];

endmodule
